slicer_serial: RTL and testbench
================================

SLICER_SERIAL -- requirements
Module: slicer_serial

Interface
REQ-001 SHALL have parameter IN_W, default 64, giving the input word width in bits.
REQ-002 SHALL have parameter OUT_W, default 32, giving the output slice width in bits.
REQ-003 SHALL derive N = IN_W/OUT_W, the number of slices per word, and IDX_W = max(1, clog2(N)).
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 in_valid  input  1  producer offers in_data.
REQ-007 in_ready  output  1  block can accept a word this cycle.
REQ-008 in_data  input  IN_W  word to be sliced.
REQ-009 msb_first  input  1  slice order, sampled with the word: 1 = MSB slice first, 0 = LSB slice first.
REQ-010 out_valid  output  1  out_data holds a valid slice.
REQ-011 out_ready  input  1  consumer accepts the slice.
REQ-012 out_data  output  OUT_W  current slice.
REQ-013 out_idx  output  IDX_W  bit-position index of the current slice; index i covers in_data[i*OUT_W +: OUT_W].
REQ-014 out_last  output  1  current slice is the final slice of the word.
REQ-015 busy  output  1  a word is held and not fully emitted.

Function
REQ-016 SHALL elaborate only when IN_W % OUT_W == 0 and N >= 2; any other parameter set SHALL stop elaboration with an error.
REQ-017 SHALL implement FSM states IDLE and EMIT.
REQ-018 An input handshake SHALL occur when in_valid && in_ready at a clock edge.
REQ-019 The input handshake SHALL register in_data and msb_first and SHALL move the FSM to EMIT.
REQ-020 in_ready SHALL equal (state==IDLE) || (out_valid && out_ready && out_last), which permits back-to-back words with no bubble.
REQ-021 The first slice SHALL be presented with out_valid=1 on the cycle after the input handshake (latency 1).
REQ-022 Slice sequence: msb_first=1 SHALL emit out_idx N-1, N-2, ... 0; msb_first=0 SHALL emit out_idx 0, 1, ... N-1.
REQ-023 out_data SHALL equal held_word[out_idx*OUT_W +: OUT_W].
REQ-024 An output handshake SHALL occur when out_valid && out_ready at a clock edge; on each one the block SHALL advance to the next slice.
REQ-025 While out_valid && !out_ready, out_data, out_idx and out_last SHALL remain stable.
REQ-026 out_last SHALL be 1 exactly when out_idx is the final index of the sequence (0 for MSB-first, N-1 for LSB-first).
REQ-027 If the last output handshake coincides with an input handshake, the new word SHALL load and its first slice SHALL appear next cycle.
REQ-028 If the last output handshake occurs without an input handshake, the FSM SHALL return to IDLE and out_valid SHALL drop next cycle.
REQ-029 Changes on msb_first or in_data while no input handshake occurs SHALL have no effect on the slices emitted.
REQ-030 busy SHALL equal (state==EMIT).
REQ-031 In IDLE, out_data, out_idx and out_last SHALL be 0.

Reset
REQ-032 rst=1 at a clock edge SHALL force IDLE and clear the held word, order flag and slice counter.
REQ-033 After reset, outputs SHALL be: out_valid=0, out_data=0, out_idx=0, out_last=0, busy=0, in_ready=1 in the cycle after rst is released.
REQ-034 Reset during EMIT SHALL discard the remaining slices, with no further slice emitted.
REQ-035 rst SHALL take priority over any simultaneous handshake.

Structure
REQ-036 A shared package slicer_pkg SHALL hold the FSM state typedef (IDLE, EMIT) and the clog2 helper function.
REQ-037 The slice-select multiplexer SHALL be a combinational sub-module named slice_select, with parameters IN_W and OUT_W, inputs word and idx, and output slice.
REQ-038 slicer_serial SHALL contain the FSM, the holding register and the index counter.

Verification
REQ-039 The bench SHALL cover: IN_W=64, OUT_W=32, msb_first=1, in_data=64'h0123456789ABCDEF, out_ready=1 -> 32'h01234567 (idx 1), then 32'h89ABCDEF (idx 0, last=1).
REQ-040 The bench SHALL cover: msb_first=0, in_data=64'hFEDCBA9876543210 -> 32'h76543210 (idx 0), then 32'hFEDCBA98 (idx 1, last=1).
REQ-041 The bench SHALL cover: out_ready held 0 for 3 cycles after the first slice -> out_data stays 32'h01234567 and in_ready=0 throughout.
REQ-042 The bench SHALL cover: two words back-to-back with in_valid held high -> 4 consecutive valid slices, no idle cycle, in_ready=1 only on the last-slice cycles.
REQ-043 The bench SHALL cover: rst asserted after the first slice of a word -> next cycle out_valid=0, busy=0, and no second slice is emitted.
REQ-044 The bench SHALL cover: IN_W=64, OUT_W=16, msb_first=1, in_data=64'h0123456789ABCDEF -> 16'h0123, 16'h4567, 16'h89AB, 16'hCDEF, with last=1 on 16'hCDEF.

Source files
------------

// File: rtl/slicer_pkg.sv
// Shared types and elaboration helpers for the serial word slicer.
package slicer_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        EMIT = 1'b1
    } state_t;

    function automatic int clog2(input int value);
        int result;
        int rem;
        result = 0;
        rem    = value - 1;
        while (rem > 0) begin
            result = result + 1;
            rem    = rem >> 1;
        end
        return result;
    endfunction

    // Index width never collapses to zero bits, even for a single slice.
    function automatic int idx_width(input int n);
        return (clog2(n) < 1) ? 1 : clog2(n);
    endfunction

endpackage

// File: rtl/slice_select.sv
// Combinational selector: picks slice idx (bits idx*OUT_W +: OUT_W) out of word.
module slice_select
    import slicer_pkg::*;
#(
    parameter int IN_W  = 64,
    parameter int OUT_W = 32,
    localparam int N     = IN_W / OUT_W,
    localparam int IDX_W = idx_width(IN_W / OUT_W)
) (
    input  logic [IN_W-1:0]  word,
    input  logic [IDX_W-1:0] idx,
    output logic [OUT_W-1:0] slice
);

    logic [OUT_W-1:0] slices [N];

    for (genvar gi = 0; gi < N; gi++) begin : g_slices
        assign slices[gi] = word[gi*OUT_W +: OUT_W];
    end

    always_comb begin
        slice = '0;
        for (int i = 0; i < N; i++) begin
            if (int'(idx) == i) begin
                slice = slices[i];
            end
        end
    end

endmodule

// File: rtl/slicer_serial.sv
// Accepts one IN_W word and emits it as IN_W/OUT_W slices, MSB- or LSB-first,
// over a valid/ready output with back-to-back word acceptance on the last slice.
module slicer_serial
    import slicer_pkg::*;
#(
    parameter int IN_W  = 64,
    parameter int OUT_W = 32,
    localparam int N     = IN_W / OUT_W,
    localparam int IDX_W = idx_width(IN_W / OUT_W)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_data,
    input  logic             msb_first,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data,
    output logic [IDX_W-1:0] out_idx,
    output logic             out_last,
    output logic             busy
);

    if ((IN_W % OUT_W) != 0 || (IN_W / OUT_W) < 2) begin : g_bad_params
        $error("slicer_serial: IN_W must be a multiple of OUT_W with at least two slices");
    end

    localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(N - 1);
    localparam logic [IDX_W-1:0] IDX_ONE = IDX_W'(1);

    state_t           state_q;
    logic [IN_W-1:0]  word_q;
    logic             msb_q;
    logic [IDX_W-1:0] idx_q;

    logic [OUT_W-1:0] slice;
    logic [IDX_W-1:0] last_idx;
    logic             at_last;
    logic             in_hs;
    logic             out_hs;

    slice_select #(
        .IN_W  (IN_W),
        .OUT_W (OUT_W)
    ) u_slice_select (
        .word  (word_q),
        .idx   (idx_q),
        .slice (slice)
    );

    assign last_idx  = msb_q ? '0 : IDX_MAX;
    assign at_last   = (idx_q == last_idx);
    assign busy      = (state_q == EMIT);
    assign out_valid = busy;
    assign out_last  = busy && at_last;
    assign out_idx   = busy ? idx_q : '0;
    assign out_data  = busy ? slice : '0;

    // Ready also on the final accepted slice so the next word loads without a bubble.
    assign in_ready  = (state_q == IDLE) || (out_valid && out_ready && out_last);
    assign in_hs     = in_valid && in_ready;
    assign out_hs    = out_valid && out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            word_q  <= '0;
            msb_q   <= 1'b0;
            idx_q   <= '0;
        end else begin
            if (in_hs) begin
                state_q <= EMIT;
                word_q  <= in_data;
                msb_q   <= msb_first;
                idx_q   <= msb_first ? IDX_MAX : '0;
            end else if (out_hs) begin
                if (at_last) begin
                    state_q <= IDLE;
                end else begin
                    idx_q <= msb_q ? (idx_q - IDX_ONE) : (idx_q + IDX_ONE);
                end
            end
        end
    end

endmodule

// File: tb/tb_slicer_serial.sv
// Bench for slicer_serial: directed scenarios on 64/32 and 64/16 instances plus
// a randomized run against a slice-queue reference model.
module tb_slicer_serial;

    localparam logic [63:0] WORD_A = 64'h0123456789ABCDEF;
    localparam logic [63:0] WORD_B = 64'hFEDCBA9876543210;

    logic        clk = 1'b0;
    logic        rst;

    logic        in_valid, in_ready, msb_first, out_valid, out_ready, out_last, busy;
    logic [63:0] in_data;
    logic [31:0] out_data;
    logic [0:0]  out_idx;

    logic        v16, rdy16, msb16, ov16, ordy16, last16, busy16;
    logic [63:0] d16;
    logic [15:0] od16;
    logic [1:0]  idx16;

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        logic [31:0] data;
        int          idx;
        bit          last;
    } slice_t;
    slice_t q[$];

    // {valid, idx, last, busy, in_ready, data}
    logic [36:0] obs;
    logic [21:0] obs16;
    assign obs   = {out_valid, out_idx, out_last, busy, in_ready, out_data};
    assign obs16 = {ov16, idx16, last16, busy16, rdy16, od16};

    always #5 clk = ~clk;

    slicer_serial #(.IN_W(64), .OUT_W(32)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .msb_first(msb_first), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .out_idx(out_idx),
        .out_last(out_last), .busy(busy)
    );

    slicer_serial #(.IN_W(64), .OUT_W(16)) dut16 (
        .clk(clk), .rst(rst), .in_valid(v16), .in_ready(rdy16),
        .in_data(d16), .msb_first(msb16), .out_valid(ov16),
        .out_ready(ordy16), .out_data(od16), .out_idx(idx16),
        .out_last(last16), .busy(busy16)
    );

    localparam logic [36:0] IDLE32 = {1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0};
    localparam logic [21:0] IDLE16 = {1'b0, 2'd0, 1'b0, 1'b0, 1'b1, 16'h0};

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b1; in_data = WORD_A; msb_first = 1'b1; out_ready = 1'b1;
        v16 = 1'b1; d16 = WORD_A; msb16 = 1'b1; ordy16 = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0; in_valid = 1'b0; v16 = 1'b0;
        @(negedge clk);
        n_checks++;
        if (obs !== IDLE32) $display("FAIL reset_w32 got %h want %h", obs, IDLE32);
        else n_pass++;
        n_checks++;
        if (obs16 !== IDLE16) $display("FAIL reset_w16 got %h want %h", obs16, IDLE16);
        else n_pass++;
        $display("test_reset: obs=%h obs16=%h", obs, obs16);
        @(posedge clk); #1;
    endtask

    task automatic test_msb_first();
        logic [36:0] ev [4];
        ev[0] = IDLE32;
        ev[1] = {1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 32'h01234567};
        ev[2] = {1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 32'h89ABCDEF};
        ev[3] = IDLE32;
        for (int c = 0; c < 4; c++) begin
            in_valid  = (c == 0);
            in_data   = (c == 0) ? WORD_A : {$urandom, $urandom};
            msb_first = (c == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            out_ready = 1'b1;
            @(negedge clk);
            n_checks++;
            if (obs !== ev[c]) $display("FAIL msb_first cyc %0d got %h want %h", c, obs, ev[c]);
            else n_pass++;
            $display("test_msb_first: cyc %0d obs=%h", c, obs);
            @(posedge clk); #1;
        end
    endtask

    task automatic test_lsb_first();
        logic [36:0] ev [4];
        ev[0] = IDLE32;
        ev[1] = {1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h76543210};
        ev[2] = {1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 32'hFEDCBA98};
        ev[3] = IDLE32;
        for (int c = 0; c < 4; c++) begin
            in_valid  = (c == 0);
            in_data   = (c == 0) ? WORD_B : {$urandom, $urandom};
            msb_first = (c == 0) ? 1'b0 : 1'($urandom_range(0, 1));
            out_ready = 1'b1;
            @(negedge clk);
            n_checks++;
            if (obs !== ev[c]) $display("FAIL lsb_first cyc %0d got %h want %h", c, obs, ev[c]);
            else n_pass++;
            $display("test_lsb_first: cyc %0d obs=%h", c, obs);
            @(posedge clk); #1;
        end
    endtask

    task automatic test_stall();
        logic [36:0] ev [7];
        ev[0] = IDLE32;
        for (int c = 1; c <= 4; c++) ev[c] = {1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 32'h01234567};
        ev[5] = {1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 32'h89ABCDEF};
        ev[6] = IDLE32;
        for (int c = 0; c < 7; c++) begin
            in_valid  = (c <= 3);
            in_data   = (c == 0) ? WORD_A : {$urandom, $urandom};
            msb_first = (c == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            out_ready = !(c >= 1 && c <= 3);
            @(negedge clk);
            n_checks++;
            if (obs !== ev[c]) $display("FAIL stall cyc %0d got %h want %h", c, obs, ev[c]);
            else n_pass++;
            $display("test_stall: cyc %0d obs=%h", c, obs);
            @(posedge clk); #1;
        end
    endtask

    task automatic test_back_to_back();
        logic [36:0] ev [6];
        ev[0] = IDLE32;
        ev[1] = {1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 32'h01234567};
        ev[2] = {1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 32'h89ABCDEF};
        ev[3] = {1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h76543210};
        ev[4] = {1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 32'hFEDCBA98};
        ev[5] = IDLE32;
        for (int c = 0; c < 6; c++) begin
            in_valid  = (c <= 2);
            in_data   = (c == 0) ? WORD_A : (c <= 2) ? WORD_B : {$urandom, $urandom};
            msb_first = (c == 0);
            out_ready = 1'b1;
            @(negedge clk);
            n_checks++;
            if (obs !== ev[c]) $display("FAIL back_to_back cyc %0d got %h want %h", c, obs, ev[c]);
            else n_pass++;
            $display("test_back_to_back: cyc %0d obs=%h", c, obs);
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset_mid();
        logic [36:0] ev [5];
        ev[0] = IDLE32;
        ev[1] = {1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 32'h01234567};
        ev[2] = IDLE32;
        ev[3] = IDLE32;
        ev[4] = IDLE32;
        for (int c = 0; c < 5; c++) begin
            rst       = (c == 1);
            in_valid  = (c <= 1);
            in_data   = WORD_A;
            msb_first = 1'b1;
            out_ready = 1'b1;
            @(negedge clk);
            n_checks++;
            if (obs !== ev[c]) $display("FAIL reset_mid cyc %0d got %h want %h", c, obs, ev[c]);
            else n_pass++;
            $display("test_reset_mid: cyc %0d obs=%h", c, obs);
            @(posedge clk); #1;
        end
        rst = 1'b0;
    endtask

    task automatic test_w16();
        logic [21:0] ev [6];
        ev[0] = IDLE16;
        ev[1] = {1'b1, 2'd3, 1'b0, 1'b1, 1'b0, 16'h0123};
        ev[2] = {1'b1, 2'd2, 1'b0, 1'b1, 1'b0, 16'h4567};
        ev[3] = {1'b1, 2'd1, 1'b0, 1'b1, 1'b0, 16'h89AB};
        ev[4] = {1'b1, 2'd0, 1'b1, 1'b1, 1'b1, 16'hCDEF};
        ev[5] = IDLE16;
        for (int c = 0; c < 6; c++) begin
            v16    = (c == 0);
            d16    = (c == 0) ? WORD_A : {$urandom, $urandom};
            msb16  = (c == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            ordy16 = 1'b1;
            @(negedge clk);
            n_checks++;
            if (obs16 !== ev[c]) $display("FAIL w16 cyc %0d got %h want %h", c, obs16, ev[c]);
            else n_pass++;
            $display("test_w16: cyc %0d obs16=%h", c, obs16);
            @(posedge clk); #1;
        end
    endtask

    // Reference: an accepted word becomes its ordered list of slices.
    task automatic push_word(input logic [63:0] w, input bit msb);
        slice_t s;
        for (int k = 0; k < 2; k++) begin
            s.idx  = msb ? (1 - k) : k;
            s.data = 32'(w >> (s.idx * 32));
            s.last = (k == 1);
            q.push_back(s);
        end
    endtask

    task automatic test_random();
        logic [36:0] ev;
        logic [63:0] w;
        bit          m, e_ready, in_hs, out_hs;
        q.delete();
        for (int c = 0; c < 400; c++) begin
            in_valid  = (c < 390) && ($urandom_range(0, 2) != 0);
            in_data   = {$urandom, $urandom};
            msb_first = 1'($urandom_range(0, 1));
            out_ready = (c >= 390) || ($urandom_range(0, 3) != 0);
            @(negedge clk);
            if (q.size() > 0) begin
                e_ready = out_ready && q[0].last;
                ev = {1'b1, 1'(q[0].idx), q[0].last, 1'b1, e_ready, q[0].data};
            end else begin
                e_ready = 1'b1;
                ev = IDLE32;
            end
            n_checks++;
            if (obs !== ev) $display("FAIL random cyc %0d got %h want %h", c, obs, ev);
            else n_pass++;
            in_hs  = in_valid && e_ready;
            out_hs = (q.size() > 0) && out_ready;
            w = in_data;
            m = msb_first;
            @(posedge clk); #1;
            if (out_hs) void'(q.pop_front());
            if (in_hs) begin
                push_word(w, m);
                $display("test_random: cyc %0d word %h msb_first=%0d accepted", c, w, m);
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        in_valid = 1'b0; in_data = '0; msb_first = 1'b0; out_ready = 1'b0;
        v16 = 1'b0; d16 = '0; msb16 = 1'b0; ordy16 = 1'b1;
        test_reset();
        test_msb_first();
        test_lsb_first();
        test_stall();
        test_back_to_back();
        test_reset_mid();
        test_w16();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
